// File: rtl/risc_spm_core_p.sv
// risc_spm_core_p: parametrised multi-cycle stored-program machine with internal program/data RAM.
// Define SPM_PERF_CNT_EN to add the saturating retired-instruction counter port instr_cnt.
module risc_spm_core_p #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 8,
  parameter int RST_PC = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              run,
  input  logic              prog_we,
  input  logic [ADDR_W-1:0] prog_addr,
  input  logic [DATA_W-1:0] prog_din,
  output logic [DATA_W-1:0] p0,
  output logic [3:0]        p1,
  output logic [ADDR_W-1:0] dbg_pc,
  output logic              busy,
  output logic              halt,
  output logic              illegal
`ifdef SPM_PERF_CNT_EN
  ,
  output logic [31:0]       instr_cnt
`endif
);
  typedef enum logic [2:0] {S_IDLE, S_FETCH, S_LDIR, S_EXEC, S_OPND, S_MEM, S_RDWB, S_HALT} state_t;
  state_t state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d, ea_q, ea_d, addr;
  logic [7:0] ir_q, ir_d;
  logic [DATA_W-1:0] r_q [4];
  logic [DATA_W-1:0] r_d [4];
  logic [DATA_W-1:0] mem_q [2**ADDR_W];
  logic [DATA_W-1:0] rdata_q, wdata, rs, rd, diff;
  logic [DATA_W:0] sum;
  logic [3:0] op;
  logic [1:0] src, dst;
  logic z_q, z_d, c_q, c_d, ill_q, ill_d, we, idle;

  assign op = ir_q[7:4];
  assign src = ir_q[3:2];
  assign dst = ir_q[1:0];
  assign rs = r_q[src];
  assign rd = r_q[dst];
  assign sum = {1'b0, rd} + {1'b0, rs};
  assign diff = rd - rs;
  assign idle = state_q == S_IDLE || state_q == S_HALT;

  always_comb begin
    state_d = state_q;
    pc_d = pc_q;
    ea_d = ea_q;
    ir_d = ir_q;
    r_d = r_q;
    z_d = z_q;
    c_d = c_q;
    ill_d = ill_q;
    addr = pc_q;
    we = 1'b0;
    wdata = prog_din;
    case (state_q)
      S_IDLE, S_HALT: begin
        // host loader owns the RAM port only while stopped; a same-cycle write lands before the first fetch
        addr = prog_addr;
        we = prog_we;
        if (run) begin
          pc_d = ADDR_W'(RST_PC);
          z_d = 1'b0;
          c_d = 1'b0;
          ill_d = 1'b0;
          state_d = S_FETCH;
        end
      end
      S_FETCH: begin
        pc_d = pc_q + ADDR_W'(1);
        state_d = S_LDIR;
      end
      S_LDIR: begin
        ir_d = rdata_q[7:0];
        state_d = S_EXEC;
      end
      S_EXEC: begin
        state_d = S_FETCH;
        case (op)
          4'h0: ;
          4'h1: begin
            r_d[dst] = sum[DATA_W-1:0];
            z_d = sum[DATA_W-1:0] == '0;
            c_d = sum[DATA_W];
          end
          4'h2: begin
            r_d[dst] = diff;
            z_d = diff == '0;
            c_d = rd < rs;
          end
          4'h3: begin
            r_d[dst] = rd & rs;
            z_d = (rd & rs) == '0;
          end
          4'h4: begin
            r_d[dst] = ~rs;
            z_d = ~rs == '0;
          end
          4'h5, 4'h6, 4'h7, 4'h8, 4'h9: begin
            pc_d = pc_q + ADDR_W'(1);
            state_d = S_OPND;
          end
          4'hF: state_d = S_HALT;
          default: begin
            ill_d = 1'b1;
            state_d = S_HALT;
          end
        endcase
      end
      S_OPND: begin
        ea_d = rdata_q[ADDR_W-1:0];
        state_d = (op == 4'h5 || op == 4'h6) ? S_MEM : S_FETCH;
        if (op == 4'h7 || (op == 4'h8 && z_q) || (op == 4'h9 && c_q)) pc_d = rdata_q[ADDR_W-1:0];
      end
      S_MEM: begin
        addr = ea_q;
        we = op == 4'h6;
        wdata = rs;
        state_d = (op == 4'h6) ? S_FETCH : S_RDWB;
      end
      S_RDWB: begin
        r_d[dst] = rdata_q;
        state_d = S_FETCH;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      pc_q <= ADDR_W'(RST_PC);
      ea_q <= '0;
      ir_q <= '0;
      r_q <= '{default: '0};
      z_q <= 1'b0;
      c_q <= 1'b0;
      ill_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q <= pc_d;
      ea_q <= ea_d;
      ir_q <= ir_d;
      r_q <= r_d;
      z_q <= z_d;
      c_q <= c_d;
      ill_q <= ill_d;
    end
  end

  // single-port RAM; write enable comes only from state, so an async reset cancels a pending WR
  always_ff @(posedge clk) begin
    if (we) mem_q[addr] <= wdata;
    rdata_q <= mem_q[addr];
  end

  assign p0 = r_q[0];
  assign p1 = op;
  assign dbg_pc = pc_q;
  assign busy = !idle;
  assign halt = state_q == S_HALT;
  assign illegal = ill_q;

`ifdef SPM_PERF_CNT_EN
  logic retire;
  logic [31:0] cnt_q;
  assign retire = (state_q == S_EXEC && !(op >= 4'h5 && op <= 4'h9)) ||
                  (state_q == S_OPND && op >= 4'h7) ||
                  (state_q == S_MEM && op == 4'h6) || state_q == S_RDWB;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else if (idle && run) cnt_q <= '0;
    else if (retire && cnt_q != '1) cnt_q <= cnt_q + 32'd1;
  end
  assign instr_cnt = cnt_q;
`endif
endmodule

// File: tb/tb_risc_spm_core_p.sv
// tb_risc_spm_core_p: directed and random programs checked against an instruction-level reference model.
module tb_risc_spm_core_p;
  logic clk, rst_n, run, prog_we;
  logic [7:0] prog_addr, prog_din, p0, dbg_pc;
  logic [3:0] p1;
  logic busy, halt, illegal;
  logic run_b, we_b;
  logic [3:0] addr_b, dbg_pc_b, p1_b;
  logic [15:0] din_b, p0_b;
  logic busy_b, halt_b, illegal_b;
`ifdef SPM_PERF_CNT_EN
  logic [31:0] cnt_a, cnt_b;
`endif
  int n_assert = 0, n_fail = 0, cyc = 0;
  logic [7:0] m_mem [256];
  logic [7:0] m_r [4];
  logic m_z, m_c, m_ill;
  int m_pc, m_cyc, m_cnt;
  logic [15:0] pb [16] = '{16'hAB50, 16'h000C, 16'h0051, 16'h000D, 16'h0014, 16'h0090, 16'h0009, 16'h00F0,
                           16'h00F0, 16'h0080, 16'h000F, 16'h00F0, 16'hFFFF, 16'h0001, 16'h00F0, 16'h00F0};

  risc_spm_core_p dut_a (
    .clk(clk), .rst_n(rst_n), .run(run), .prog_we(prog_we), .prog_addr(prog_addr), .prog_din(prog_din),
    .p0(p0), .p1(p1), .dbg_pc(dbg_pc), .busy(busy), .halt(halt), .illegal(illegal)
`ifdef SPM_PERF_CNT_EN
    , .instr_cnt(cnt_a)
`endif
  );

  risc_spm_core_p #(.DATA_W(16), .ADDR_W(4)) dut_b (
    .clk(clk), .rst_n(rst_n), .run(run_b), .prog_we(we_b), .prog_addr(addr_b), .prog_din(din_b),
    .p0(p0_b), .p1(p1_b), .dbg_pc(dbg_pc_b), .busy(busy_b), .halt(halt_b), .illegal(illegal_b)
`ifdef SPM_PERF_CNT_EN
    , .instr_cnt(cnt_b)
`endif
  );

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_assert++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic wr(input logic [7:0] a, input logic [7:0] d);
    m_mem[a] = d;
    prog_we = 1;
    prog_addr = a;
    prog_din = d;
    tick();
    prog_we = 0;
  endtask

  task automatic start();
    run = 1;
    tick();
    run = 0;
    cyc = 0;
  endtask

  // executes the program in m_mem from address 0 at instruction granularity
  task automatic model_run();
    logic [7:0] ins, opnd;
    int s, d, t;
    m_pc = 0; m_z = 0; m_c = 0; m_ill = 0; m_cyc = 0; m_cnt = 0;
    opnd = 0;
    for (int k = 0; k < 500; k++) begin
      ins = m_mem[m_pc];
      m_pc = (m_pc + 1) % 256;
      s = int'(ins[3:2]);
      d = int'(ins[1:0]);
      m_cnt++;
      if (ins[7:4] >= 4'h5 && ins[7:4] <= 4'h9) begin
        opnd = m_mem[m_pc];
        m_pc = (m_pc + 1) % 256;
      end
      case (ins[7:4])
        4'h0: m_cyc += 3;
        4'h1: begin t = int'(m_r[d]) + int'(m_r[s]); m_c = t > 255; m_r[d] = 8'(t); m_z = m_r[d] == 0; m_cyc += 3; end
        4'h2: begin m_c = m_r[d] < m_r[s]; m_r[d] = m_r[d] - m_r[s]; m_z = m_r[d] == 0; m_cyc += 3; end
        4'h3: begin m_r[d] = m_r[d] & m_r[s]; m_z = m_r[d] == 0; m_cyc += 3; end
        4'h4: begin m_r[d] = ~m_r[s]; m_z = m_r[d] == 0; m_cyc += 3; end
        4'h5: begin m_r[d] = m_mem[opnd]; m_cyc += 6; end
        4'h6: begin m_mem[opnd] = m_r[s]; m_cyc += 5; end
        4'h7: begin m_pc = int'(opnd); m_cyc += 4; end
        4'h8: begin if (m_z) m_pc = int'(opnd); m_cyc += 4; end
        4'h9: begin if (m_c) m_pc = int'(opnd); m_cyc += 4; end
        4'hF: begin m_cyc += 3; return; end
        default: begin m_ill = 1; m_cyc += 3; return; end
      endcase
    end
  endtask

  task automatic run_cmp(input string tag);
    while (!halt && cyc < 1000) tick();
    chk({tag, ".halt"}, halt, 1);
    chk({tag, ".busy"}, busy, 0);
    chk({tag, ".cycles"}, cyc, m_cyc);
    chk({tag, ".p0"}, p0, m_r[0]);
    chk({tag, ".pc"}, dbg_pc, m_pc);
    chk({tag, ".illegal"}, illegal, m_ill);
    for (int i = 0; i < 16; i++) chk($sformatf("%s.mem%0h", tag, 8'h80 + i), dut_a.mem_q[8'h80 + i], m_mem[8'h80 + i]);
`ifdef SPM_PERF_CNT_EN
    chk({tag, ".instr_cnt"}, cnt_a, m_cnt);
`endif
  endtask

  task automatic rand_prog();
    int ops[$];
    int starts[$];
    int pos, n;
    pos = 0;
    n = 4 + int'($urandom % 9);
    for (int i = 0; i < n; i++) begin
      ops.push_back(int'($urandom % 10));
      starts.push_back(pos);
      pos += (ops[i] >= 5) ? 2 : 1;
    end
    starts.push_back(pos);
    for (int i = 0; i < n; i++) begin
      wr(8'(starts[i]), {4'(ops[i]), 4'($urandom)});
      if (ops[i] >= 7) wr(8'(starts[i] + 1), 8'(starts[$urandom_range(n, i + 1)]));
      else if (ops[i] >= 5) wr(8'(starts[i] + 1), 8'h80 | 8'($urandom % 16));
    end
    wr(8'(pos), ($urandom % 4 == 0) ? {4'(10 + $urandom % 5), 4'h0} : 8'hF0);
  endtask

  initial begin
    rst_n = 0; run = 0; prog_we = 0; prog_addr = 0; prog_din = 0;
    run_b = 0; we_b = 0; addr_b = 0; din_b = 0;
    m_r = '{default: 0};
    repeat (3) @(posedge clk);
    #1;
    chk("rst.p0", p0, 0);
    chk("rst.p1", p1, 0);
    chk("rst.pc", dbg_pc, 0);
    chk("rst.busy", busy, 0);
    chk("rst.halt", halt, 0);
    chk("rst.illegal", illegal, 0);
    rst_n = 1;
    tick();
    for (int i = 0; i < 16; i++) wr(8'h80 + 8'(i), 8'($urandom));
    wr(8'h80, 8'hF0); wr(8'h81, 8'h20); wr(8'h82, 8'h5A);
    wr(8'h83, 8'hFF); wr(8'h84, 8'h01); wr(8'h85, 8'h33);

    // ADD with carry, BRC taken, BRZ not taken
    wr(0, 8'h50); wr(1, 8'h80); wr(2, 8'h51); wr(3, 8'h81); wr(4, 8'h14); wr(5, 8'h90);
    wr(6, 8'h09); wr(7, 8'hF0); wr(8, 8'hF0); wr(9, 8'h80); wr(10, 8'h30); wr(11, 8'hF0); wr(8'h30, 8'hF0);
    model_run(); start(); run_cmp("alu");
    chk("alu.p0_const", p0, 8'h10);
    chk("alu.pc_const", dbg_pc, 8'h0C);
    chk("alu.cyc_const", cyc, 26);

    // SUB to zero, BRZ taken
    wr(0, 8'h20); wr(1, 8'h80); wr(2, 8'h40); wr(8'h40, 8'hF0);
    model_run(); start();
    repeat (7) tick();
    chk("brz.pc_at_4", dbg_pc, 8'h40);
    run_cmp("brz");
    chk("brz.p0_const", p0, 0);

    // WR then RD, copy r3 into r0
    wr(0, 8'h52); wr(1, 8'h82); wr(2, 8'h68); wr(3, 8'h80); wr(4, 8'h53); wr(5, 8'h80);
    wr(6, 8'h20); wr(7, 8'h1C); wr(8, 8'hF0);
    model_run(); start(); run_cmp("mem");
    chk("mem.p0_const", p0, 8'h5A);
    chk("mem.word_const", dut_a.mem_q[8'h80], 8'h5A);
    wr(0, 8'h68); wr(1, 8'h80); wr(2, 8'hF0);
    model_run(); start(); run_cmp("wr");
    chk("wr.cyc_const", cyc, 8);
    wr(0, 8'h53);
    model_run(); start(); run_cmp("rd");
    chk("rd.cyc_const", cyc, 9);

    // BRC after FF+01
    wr(0, 8'h50); wr(1, 8'h83); wr(2, 8'h51); wr(3, 8'h84); wr(4, 8'h14); wr(5, 8'h90);
    wr(6, 8'h20); wr(7, 8'hF0); wr(8'h20, 8'hF0);
    model_run(); start(); run_cmp("brc");
    chk("brc.pc_const", dbg_pc, 8'h21);

    // program write and run in the same cycle
    wr(0, 8'h00); wr(1, 8'hB0);
    m_mem[0] = 8'hF0;
    model_run();
    prog_we = 1; prog_addr = 0; prog_din = 8'hF0; run = 1;
    tick();
    prog_we = 0; run = 0; cyc = 0;
    run_cmp("wr_run");
    chk("wr_run.pc_const", dbg_pc, 1);

    // illegal opcode, restart, write attempt while busy
    wr(0, 8'hB0);
    model_run(); start(); run_cmp("ill");
    chk("ill.flag_const", illegal, 1);
    wr(0, 0); wr(1, 0); wr(2, 0); wr(3, 0); wr(4, 8'hB0); wr(8'h90, 8'h11);
    model_run(); start();
    chk("restart.illegal", illegal, 0);
    chk("restart.pc", dbg_pc, 0);
    chk("restart.busy", busy, 1);
    prog_we = 1; prog_addr = 8'h90; prog_din = 8'hEE;
    tick();
    prog_we = 0;
    run_cmp("restart");
    chk("busy_write.word", dut_a.mem_q[8'h90], 8'h11);

    // reset pulse while a WR sits in MEM
    wr(0, 8'h68); wr(1, 8'h85); wr(2, 8'hF0);
    start();
    repeat (4) tick();
    rst_n = 0;
    #1;
    chk("abort.busy", busy, 0);
    tick();
    rst_n = 1;
    m_r = '{default: 0};
    tick();
    chk("abort.word", dut_a.mem_q[8'h85], 8'h33);
    chk("abort.p0", p0, 0);
    chk("abort.pc", dbg_pc, 0);

    for (int p = 0; p < 10; p++) begin
      rand_prog();
      wr(8'h80 | 8'($urandom % 16), 8'($urandom));
      wr(8'h80 | 8'($urandom % 16), 8'($urandom));
      model_run(); start(); run_cmp($sformatf("rnd%0d", p));
    end

    // 16-bit data, 4-bit address: wrap-around add and pc wrap from the last word
    for (int i = 0; i < 16; i++) begin
      we_b = 1; addr_b = 4'(i); din_b = pb[i];
      tick();
    end
    we_b = 0;
    run_b = 1;
    tick();
    run_b = 0;
    cyc = 0;
    while (!halt_b && cyc < 1000) tick();
    chk("w16.halt", halt_b, 1);
    chk("w16.busy", busy_b, 0);
    chk("w16.p0", p0_b, 0);
    chk("w16.pc_wrap", dbg_pc_b, 0);
    chk("w16.illegal", illegal_b, 0);
    chk("w16.cycles", cyc, 26);
`ifdef SPM_PERF_CNT_EN
    chk("w16.instr_cnt", cnt_b, 6);
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
